// File: rtl/scpad_dram_req_mq_pkg.sv
// -----------------------------------------------------------------------------
// scpad_pkg
// Shared types and defaults for the scratchpad DRAM request queue.
//   dram_req_t       : one single-beat DRAM request as held in the queue
//   DRAM_ADDR_WIDTH  : default DRAM address width
//   DRAM_ID_WIDTH    : default transaction ID width
//   DRAM_NREQ_WIDTH  : default width of sub_id / num_request
//   DRAM_DATA_WIDTH  : default write-data beat width
//   SCPAD_DRQ_DEPTH  : default queue depth
// -----------------------------------------------------------------------------
package scpad_pkg;

   localparam int DRAM_ADDR_WIDTH = 32;
   localparam int DRAM_ID_WIDTH   = 4;
   localparam int DRAM_NREQ_WIDTH = 3;
   localparam int DRAM_DATA_WIDTH = 128;
   localparam int SCPAD_DRQ_DEPTH = 8;

   typedef struct packed {
      logic                       write;
      logic [DRAM_ADDR_WIDTH-1:0] addr;
      logic [DRAM_ID_WIDTH-1:0]   id;
      logic [DRAM_NREQ_WIDTH-1:0] sub_id;
      logic [DRAM_NREQ_WIDTH-1:0] num_req;
      logic [DRAM_DATA_WIDTH-1:0] wdata;
   } dram_req_t;

endpackage

// File: rtl/scpad_dram_req_mq_if.sv
// -----------------------------------------------------------------------------
// scpad_dram_req_mq_if
// Bundles the request-side channels, the DRAM-side valid/ready port and the
// queue status outputs of scpad_dram_req_mq.
//   master : the requesting side (channels + DRAM controller model)
//   slave  : the request queue itself
// -----------------------------------------------------------------------------
interface scpad_dram_req_mq_if
   import scpad_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = SCPAD_DRQ_DEPTH,
   parameter int ADDR_W = DRAM_ADDR_WIDTH,
   parameter int ID_W   = DRAM_ID_WIDTH,
   parameter int DATA_W = DRAM_DATA_WIDTH,
   parameter int NREQ_W = DRAM_NREQ_WIDTH
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [NUM_CH-1:0]        in_write;
   logic [NUM_CH*ADDR_W-1:0] in_addr;
   logic [NUM_CH*ID_W-1:0]   in_id;
   logic [NUM_CH*NREQ_W-1:0] in_sub_id;
   logic [NUM_CH*NREQ_W-1:0] in_num_req;
   logic [NUM_CH*DATA_W-1:0] in_wdata;

   logic                     out_valid;
   logic                     out_ready;
   logic                     out_write;
   logic [ADDR_W-1:0]        out_addr;
   logic [ID_W-1:0]          out_id;
   logic [NREQ_W-1:0]        out_sub_id;
   logic [DATA_W-1:0]        out_wdata;

   logic [OCC_W-1:0]         occupancy;
   logic                     full;
   logic                     empty;
   logic                     burst_complete;
   logic [ID_W-1:0]          burst_id;

   modport master (
      output in_valid, in_write, in_addr, in_id, in_sub_id, in_num_req, in_wdata,
      output out_ready,
      input  in_ready, out_valid, out_write, out_addr, out_id, out_sub_id, out_wdata,
      input  occupancy, full, empty, burst_complete, burst_id
   );

   modport slave (
      input  in_valid, in_write, in_addr, in_id, in_sub_id, in_num_req, in_wdata,
      input  out_ready,
      output in_ready, out_valid, out_write, out_addr, out_id, out_sub_id, out_wdata,
      output occupancy, full, empty, burst_complete, burst_id
   );

endinterface

// File: rtl/scpad_dram_req_mq_rr_arb.sv
// -----------------------------------------------------------------------------
// scpad_rr_arb
// NUM_CH-wide round-robin arbiter. Grants the first requester at or after the
// internal pointer; the pointer moves just past the granted channel only when
// the grant is actually used (advance_i).
//   CLK, nRST   : clock, asynchronous active-low reset (pointer -> channel 0)
//   req_i       : per-channel request
//   advance_i   : the current grant was consumed this cycle
//   grant_o     : one-hot grant (all zero when nothing requests)
//   grant_idx_o : index of the granted channel (0 when nothing requests)
// -----------------------------------------------------------------------------
module scpad_rr_arb #(
   parameter int NUM_CH = 2
) (
   input  logic                                     CLK,
   input  logic                                     nRST,
   input  logic [NUM_CH-1:0]                        req_i,
   input  logic                                     advance_i,
   output logic [NUM_CH-1:0]                        grant_o,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant_idx_o
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CH_W-1:0]   ptr_q;
   logic [CH_W-1:0]   ptr_d;
   logic [CH_W-1:0]   idx_s;
   logic              found_s;
   logic [NUM_CH-1:0] grant_s;

   function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
      int sum;
      sum = (int'(base) + off) % NUM_CH;
      return CH_W'(sum);
   endfunction

   // Scan from the pointer and keep the first requester found
   always_comb begin
      found_s = 1'b0;
      idx_s   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found_s && req_i[wrap_idx(ptr_q, i)]) begin
            found_s = 1'b1;
            idx_s   = wrap_idx(ptr_q, i);
         end else begin
            found_s = found_s;
         end
      end
   end

   // One-hot grant from the selected index
   always_comb begin
      grant_s = '0;
      if (found_s) begin
         grant_s[idx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   // Pointer moves to the channel after the one that was served
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         if (idx_s == CH_W'(NUM_CH - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = idx_s + CH_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign grant_o     = grant_s;
   assign grant_idx_o = idx_s;

endmodule

// File: rtl/scpad_dram_req_mq.sv
// -----------------------------------------------------------------------------
// scpad_dram_req_mq
// Multi-channel DRAM request queue. NUM_CH channels are round-robin arbitrated
// into a DEPTH-entry in-order FIFO that drains to the DRAM controller over a
// valid/ready port. A per-ID beat counter pulses burst_complete one cycle after
// the last beat of a burst is accepted by DRAM.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : scpad_dram_req_mq_if.slave (request channels, DRAM port, status)
// Build option:
//   SCPAD_DRQ_BYPASS_EN : when defined, a request granted while the FIFO is
//                         empty is presented on out_* in the same cycle and is
//                         not stored if DRAM takes it immediately.
// -----------------------------------------------------------------------------
module scpad_dram_req_mq
   import scpad_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = SCPAD_DRQ_DEPTH,
   parameter int ADDR_W = DRAM_ADDR_WIDTH,
   parameter int ID_W   = DRAM_ID_WIDTH,
   parameter int DATA_W = DRAM_DATA_WIDTH,
   parameter int NREQ_W = DRAM_NREQ_WIDTH
) (
   input  logic               CLK,
   input  logic               nRST,
   scpad_dram_req_mq_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NID   = 1 << ID_W;
   localparam int CNT_W = NREQ_W + 1;

   // FIFO storage (not reset)
   logic              mem_write_q [DEPTH];
   logic [ADDR_W-1:0] mem_addr_q  [DEPTH];
   logic [ID_W-1:0]   mem_id_q    [DEPTH];
   logic [NREQ_W-1:0] mem_sub_q   [DEPTH];
   logic [NREQ_W-1:0] mem_num_q   [DEPTH];
   logic [DATA_W-1:0] mem_wdata_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [NREQ_W-1:0] cnt_q [NID];
   logic              burst_complete_q;
   logic [ID_W-1:0]   burst_id_q;

   logic [NUM_CH-1:0] grant_s;
   logic [CH_W-1:0]   gidx_s;
   logic              any_grant_s;
   logic              empty_s, full_s;
   logic              enq_acc_s, wr_en_s, deq_s, rd_adv_s, bypass_s;
   logic              out_valid_s;

   logic              sel_write_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [ID_W-1:0]   sel_id_s;
   logic [NREQ_W-1:0] sel_sub_s;
   logic [NREQ_W-1:0] sel_num_s;
   logic [DATA_W-1:0] sel_wdata_s;

   logic              head_write_s;
   logic [ADDR_W-1:0] head_addr_s;
   logic [ID_W-1:0]   head_id_s;
   logic [NREQ_W-1:0] head_sub_s;
   logic [NREQ_W-1:0] head_num_s;
   logic [DATA_W-1:0] head_wdata_s;

   logic [CNT_W-1:0]  eff_num_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              done_s;

   scpad_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .CLK         (CLK),
      .nRST        (nRST),
      .req_i       (bus.in_valid),
      .advance_i   (enq_acc_s),
      .grant_o     (grant_s),
      .grant_idx_o (gidx_s)
   );

   // Pointer MSB distinguishes a full wrap from an empty queue
   assign empty_s     = (wr_ptr_q == rd_ptr_q);
   assign full_s      = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign any_grant_s = |grant_s;
   // full is taken from registered pointers, so a dequeue never frees a slot in the same cycle
   assign enq_acc_s   = any_grant_s & ~full_s;

`ifdef SCPAD_DRQ_BYPASS_EN
   assign bypass_s    = empty_s & any_grant_s;
`else
   assign bypass_s    = 1'b0;
`endif

   assign out_valid_s = ~empty_s | bypass_s;
   assign deq_s       = out_valid_s & bus.out_ready;
   // A bypassed beat taken straight away never touches the storage or pointers
   assign wr_en_s     = enq_acc_s & ~(bypass_s & bus.out_ready);
   assign rd_adv_s    = deq_s & ~bypass_s;

   // Fields of the granted channel
   always_comb begin
      sel_write_s = bus.in_write[gidx_s];
      sel_addr_s  = bus.in_addr[int'(gidx_s)*ADDR_W +: ADDR_W];
      sel_id_s    = bus.in_id[int'(gidx_s)*ID_W +: ID_W];
      sel_sub_s   = bus.in_sub_id[int'(gidx_s)*NREQ_W +: NREQ_W];
      sel_num_s   = bus.in_num_req[int'(gidx_s)*NREQ_W +: NREQ_W];
      sel_wdata_s = bus.in_wdata[int'(gidx_s)*DATA_W +: DATA_W];
   end

   // Head of queue; zero while nothing is presented so reset values are clean
   always_comb begin
      head_write_s = 1'b0;
      head_addr_s  = '0;
      head_id_s    = '0;
      head_sub_s   = '0;
      head_num_s   = '0;
      head_wdata_s = '0;
      if (!empty_s) begin
         head_write_s = mem_write_q[rd_ptr_q[IDX_W-1:0]];
         head_addr_s  = mem_addr_q[rd_ptr_q[IDX_W-1:0]];
         head_id_s    = mem_id_q[rd_ptr_q[IDX_W-1:0]];
         head_sub_s   = mem_sub_q[rd_ptr_q[IDX_W-1:0]];
         head_num_s   = mem_num_q[rd_ptr_q[IDX_W-1:0]];
         head_wdata_s = mem_wdata_q[rd_ptr_q[IDX_W-1:0]];
`ifdef SCPAD_DRQ_BYPASS_EN
      end else if (bypass_s) begin
         head_write_s = sel_write_s;
         head_addr_s  = sel_addr_s;
         head_id_s    = sel_id_s;
         head_sub_s   = sel_sub_s;
         head_num_s   = sel_num_s;
         head_wdata_s = sel_wdata_s;
`endif
      end else begin
         head_write_s = 1'b0;
      end
   end

   // Next-state of the FIFO pointers
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_adv_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // FIFO pointer registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage write; contents are only meaningful once written
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         mem_write_q[wr_ptr_q[IDX_W-1:0]] <= sel_write_s;
         mem_addr_q[wr_ptr_q[IDX_W-1:0]]  <= sel_addr_s;
         mem_id_q[wr_ptr_q[IDX_W-1:0]]    <= sel_id_s;
         mem_sub_q[wr_ptr_q[IDX_W-1:0]]   <= sel_sub_s;
         mem_num_q[wr_ptr_q[IDX_W-1:0]]   <= sel_num_s;
         mem_wdata_q[wr_ptr_q[IDX_W-1:0]] <= sel_wdata_s;
      end
   end

   // Burst accounting: num_req of 0 means a single-beat burst; compare one bit wider so the increment cannot alias
   always_comb begin
      eff_num_s = (head_num_s == '0) ? CNT_W'(1) : {1'b0, head_num_s};
      cnt_inc_s = {1'b0, cnt_q[head_id_s]} + CNT_W'(1);
      done_s    = deq_s & (cnt_inc_s == eff_num_s);
   end

   // Per-ID beat counters and the registered completion pulse
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NID; i++) begin
            cnt_q[i] <= '0;
         end
         burst_complete_q <= 1'b0;
         burst_id_q       <= '0;
      end else begin
         burst_complete_q <= done_s;
         if (deq_s) begin
            if (done_s) begin
               cnt_q[head_id_s] <= '0;
               burst_id_q       <= head_id_s;
            end else begin
               cnt_q[head_id_s] <= cnt_inc_s[NREQ_W-1:0];
            end
         end
      end
   end

   assign bus.in_ready       = grant_s & {NUM_CH{~full_s}};
   assign bus.out_valid      = out_valid_s;
   assign bus.out_write      = head_write_s;
   assign bus.out_addr       = head_addr_s;
   assign bus.out_id         = head_id_s;
   assign bus.out_sub_id     = head_sub_s;
   assign bus.out_wdata      = head_wdata_s;
   assign bus.occupancy      = OCC_W'(wr_ptr_q - rd_ptr_q);
   assign bus.full           = full_s;
   assign bus.empty          = empty_s;
   assign bus.burst_complete = burst_complete_q;
   assign bus.burst_id       = burst_id_q;

endmodule
